// File: rtl/knn_pkg.sv
// Shared definitions for the k-nearest-neighbour blocks: width helpers and the
// vote FSM state type.
package knn_pkg;

   // Bits needed to hold the value v (v=0 still takes one bit).
   function automatic int unsigned log2(input int unsigned v);
      for (int unsigned n = 1; n < 32; n++) begin
         if ((v >> n) == 0) return n;
      end
      return 32;
   endfunction

   function automatic int unsigned num_classes(input int unsigned l);
      return 32'd1 << l;
   endfunction

   typedef enum logic [1:0] {
      Idle,
      Count,
      Scan,
      Done
   } vote_state_e;

endpackage

// File: rtl/knn_vote_bank.sv
// Bank of 2^L vote counters: synchronous clear, single increment port and one
// combinational read port.
module knn_vote_bank
   import knn_pkg::*;
#(
   parameter int unsigned L  = 2,
   parameter int unsigned CW = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_i,
   input  logic          inc_i,
   input  logic [L-1:0]  inc_idx_i,
   input  logic [L-1:0]  rd_idx_i,
   output logic [CW-1:0] rd_cnt_o
);

   localparam int unsigned N = num_classes(L);

   logic [CW-1:0] cnt_q [N];
   logic [CW-1:0] cnt_d [N];

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         for (int i = 0; i < N; i++) cnt_d[i] = '0;
      end else if (inc_i) begin
         cnt_d[inc_idx_i] = cnt_q[inc_idx_i] + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) cnt_q[i] <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign rd_cnt_o = cnt_q[rd_idx_i];

endmodule

// File: rtl/knn_vote.sv
// Majority vote over K ordered neighbours: count labels one per cycle, then scan
// classes one per cycle for the strict maximum (lowest class wins ties).
module knn_vote
   import knn_pkg::*;
#(
   parameter int unsigned W = 8,
   parameter int unsigned K = 2,
   parameter int unsigned L = 2,
   localparam int unsigned CW = log2(K)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W*K-1:0] in_vals,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [L-1:0]   out_class,
   output logic [CW-1:0]  out_votes
);

   vote_state_e    state_q, state_d;
   logic [W*K-1:0] vals_q, vals_d;
   logic [CW-1:0]  idx_q, idx_d;
   logic [L-1:0]   cls_q, cls_d;
   logic [L-1:0]   best_q, best_d;
   logic [CW-1:0]  bestv_q, bestv_d;
   logic [L-1:0]   oc_q, oc_d;
   logic [CW-1:0]  ov_q, ov_d;

   logic           clr, inc;
   logic [L-1:0]   lbl;
   logic [CW-1:0]  rd_cnt;

   knn_vote_bank #(
      .L  (L),
      .CW (CW)
   ) u_bank (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (clr),
      .inc_i     (inc),
      .inc_idx_i (lbl),
      .rd_idx_i  (cls_q),
      .rd_cnt_o  (rd_cnt)
   );

   // Label of the neighbour currently being counted; upper entry bits ignored.
   always_comb begin
      lbl = '0;
      for (int i = 0; i < K; i++) begin
         if (idx_q == CW'(i)) lbl = vals_q[i*W +: L];
      end
   end

   always_comb begin
      state_d = state_q;
      vals_d  = vals_q;
      idx_d   = idx_q;
      cls_d   = cls_q;
      best_d  = best_q;
      bestv_d = bestv_q;
      oc_d    = oc_q;
      ov_d    = ov_q;
      clr     = 1'b0;
      inc     = 1'b0;
      unique case (state_q)
         Idle: begin
            if (in_valid && in_ready) begin
               vals_d  = in_vals;
               clr     = 1'b1;
               idx_d   = '0;
               state_d = Count;
            end
         end
         Count: begin
            inc   = 1'b1;
            idx_d = idx_q + CW'(1);
            if (idx_q == CW'(K - 1)) begin
               cls_d   = '0;
               best_d  = '0;
               bestv_d = '0;
               state_d = Scan;
            end
         end
         Scan: begin
            if (rd_cnt > bestv_q) begin
               best_d  = cls_q;
               bestv_d = rd_cnt;
            end
            cls_d = cls_q + L'(1);
            // Last class: latch the result including this cycle's compare.
            if (cls_q == '1) begin
               oc_d    = best_d;
               ov_d    = bestv_d;
               state_d = Done;
            end
         end
         Done: begin
            if (out_ready) state_d = Idle;
         end
         default: state_d = Idle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= Idle;
         vals_q  <= '0;
         idx_q   <= '0;
         cls_q   <= '0;
         best_q  <= '0;
         bestv_q <= '0;
         oc_q    <= '0;
         ov_q    <= '0;
      end else begin
         state_q <= state_d;
         vals_q  <= vals_d;
         idx_q   <= idx_d;
         cls_q   <= cls_d;
         best_q  <= best_d;
         bestv_q <= bestv_d;
         oc_q    <= oc_d;
         ov_q    <= ov_d;
      end
   end

   assign in_ready  = (state_q == Idle) && !rst;
   assign out_valid = (state_q == Done);
   assign out_class = oc_q;
   assign out_votes = ov_q;

endmodule

// File: tb/tb_knn_vote.sv
// Self-checking bench for knn_vote: directed and random vectors on a K=2 and a
// K=3 instance, compared against a label-histogram reference.
module tb_knn_vote;

   logic        clk = 1'b0;
   logic        rst;
   always #5 clk = ~clk;

   logic        in_valid, in_ready, out_valid, out_ready;
   logic [15:0] in_vals;
   logic [1:0]  out_class, out_votes;

   logic        in_valid3, in_ready3, out_valid3, out_ready3;
   logic [23:0] in_vals3;
   logic [1:0]  out_class3, out_votes3;

   int checks = 0;
   int errors = 0;

   knn_vote #(.W(8), .K(2), .L(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_vals   (in_vals),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_class (out_class),
      .out_votes (out_votes)
   );

   knn_vote #(.W(8), .K(3), .L(2)) dut3 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid3),
      .in_ready  (in_ready3),
      .in_vals   (in_vals3),
      .out_valid (out_valid3),
      .out_ready (out_ready3),
      .out_class (out_class3),
      .out_votes (out_votes3)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Histogram of labels, then first class holding the maximum count.
   function automatic void model(input logic [23:0] v, input int k,
                                 output logic [1:0] cls, output logic [1:0] votes);
      int cnt [4];
      int best;
      for (int c = 0; c < 4; c++) cnt[c] = 0;
      for (int i = 0; i < k; i++) cnt[v[i*8 +: 2]]++;
      best = 0;
      for (int c = 1; c < 4; c++) if (cnt[c] > cnt[best]) best = c;
      cls   = 2'(best);
      votes = 2'(cnt[best]);
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Called at a negedge. Leaves the DUT in DONE if rel is 0.
   task automatic run2(input logic [15:0] v, input string tag, input bit rel);
      logic [1:0] ec, ev;
      int n;
      model({8'h00, v}, 2, ec, ev);
      in_valid = 1'b1;
      in_vals  = v;
      n = 0;
      while (!in_ready && n < 50) begin step(); n++; end
      check({tag, " accept"}, 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      in_vals  = 16'($urandom);
      n = 1;
      while (!out_valid && n < 50) begin step(); n++; end
      check({tag, " latency"}, n, 7);
      check({tag, " class"}, 32'(out_class), 32'(ec));
      check({tag, " votes"}, 32'(out_votes), 32'(ev));
      if (rel) begin
         out_ready = 1'b1;
         step();
         out_ready = 1'b0;
         check({tag, " idle_ready"}, 32'(in_ready), 32'd1);
         check({tag, " held_class"}, 32'(out_class), 32'(ec));
      end
   endtask

   task automatic run3(input logic [23:0] v, input string tag);
      logic [1:0] ec, ev;
      int n;
      model(v, 3, ec, ev);
      in_valid3 = 1'b1;
      in_vals3  = v;
      n = 0;
      while (!in_ready3 && n < 50) begin step(); n++; end
      check({tag, " accept"}, 32'(in_ready3), 32'd1);
      step();
      in_valid3 = 1'b0;
      in_vals3  = 24'($urandom);
      n = 1;
      while (!out_valid3 && n < 50) begin step(); n++; end
      check({tag, " latency"}, n, 8);
      check({tag, " class"}, 32'(out_class3), 32'(ec));
      check({tag, " votes"}, 32'(out_votes3), 32'(ev));
      out_ready3 = 1'b1;
      step();
      out_ready3 = 1'b0;
   endtask

   initial begin
      int seen;
      rst        = 1'b1;
      in_valid   = 1'b0;
      in_vals    = '0;
      out_ready  = 1'b0;
      in_valid3  = 1'b0;
      in_vals3   = '0;
      out_ready3 = 1'b0;
      @(negedge clk);
      check("rst in_ready", 32'(in_ready), 32'd0);
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst out_class", 32'(out_class), 32'd0);
      check("rst out_votes", 32'(out_votes), 32'd0);
      step();
      rst = 1'b0;
      step();
      check("rel in_ready", 32'(in_ready), 32'd1);

      // Unanimous, then reset while holding the result in DONE.
      run2(16'h1327, "unanimous", 1'b0);
      rst = 1'b1;
      #1;
      check("midrst out_valid", 32'(out_valid), 32'd0);
      check("midrst out_class", 32'(out_class), 32'd0);
      check("midrst out_votes", 32'(out_votes), 32'd0);
      check("midrst in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      step();

      // Tie, then backpressure with a new vector waiting.
      run2(16'h0906, "tie", 1'b0);
      in_valid = 1'b1;
      in_vals  = 16'h1327;
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp out_valid", 32'(out_valid), 32'd1);
         check("bp class", 32'(out_class), 32'd1);
         check("bp votes", 32'(out_votes), 32'd1);
         check("bp in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("bp release in_ready", 32'(in_ready), 32'd1);
      run2(16'h1327, "bp_new", 1'b1);

      // Abort during COUNT.
      in_valid = 1'b1;
      in_vals  = 16'h2233;
      step();
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("abort out_valid", 32'(out_valid), 32'd0);
      check("abort in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (out_valid) seen++;
      end
      check("abort no out_valid", seen, 0);
      run2(16'h0101, "after_abort", 1'b1);

      for (int i = 0; i < 20; i++) run2(16'($urandom), "rand2", 1'b1);

      run3(24'h320E04, "k3_directed");
      for (int i = 0; i < 10; i++) run3(24'($urandom), "rand3");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

endmodule
